// File: rtl/stream_serializer_if.sv
// ---------------------------------------------------------------------------
// stream_serializer_if
// Handshake bundle for stream_serializer.
//   Upstream side  : i_data, i_len, i_valid -> serializer ; o_ready <- serializer
//   Downstream side: o_data, o_valid, o_last <- serializer ; i_ready -> serializer
// Modports:
//   slave  - the serializer's view (consumes i_*, drives o_*)
//   master - the environment's view (drives i_*, observes o_*)
// ---------------------------------------------------------------------------
interface stream_serializer_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_WORDS = 4,
    parameter int LEN_W     = $clog2(NUM_WORDS + 1)
);
    logic [WIDTH*NUM_WORDS-1:0] i_data;
    logic [LEN_W-1:0]           i_len;
    logic                       i_valid;
    logic                       o_ready;
    logic [WIDTH-1:0]           o_data;
    logic                       o_valid;
    logic                       i_ready;
    logic                       o_last;

    modport slave (
        input  i_data, i_len, i_valid, i_ready,
        output o_ready, o_data, o_valid, o_last
    );

    modport master (
        output i_data, i_len, i_valid, i_ready,
        input  o_ready, o_data, o_valid, o_last
    );
endinterface

// File: rtl/stream_serializer.sv
// ---------------------------------------------------------------------------
// stream_serializer
// Splits a NUM_WORDS*WIDTH parallel word into WIDTH-bit beats with valid/ready
// flow control on both sides, a per-word beat count and an end-of-word flag.
// An active register feeds the output while a pending register catches the
// next word, so back-to-back words stream without bubbles.
// Ports:
//   clk        clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   io_bus     stream_serializer_if.slave (data/len/valid/ready in and out)
//   o_busy     active or pending register occupied
// ---------------------------------------------------------------------------
module stream_serializer #(
    parameter int WIDTH         = 8,
    parameter int NUM_WORDS     = 4,
    parameter bit LITTLE_ENDIAN = 1'b0
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    stream_serializer_if.slave    io_bus,
    output logic                  o_busy
);
    localparam int LEN_W = $clog2(NUM_WORDS + 1);
    localparam int DW    = WIDTH * NUM_WORDS;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_FULL   = 2'b10
    } state_t;

    // Out-of-range lengths (0 or above NUM_WORDS) mean a full word.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] res;
        if ((len == {LEN_W{1'b0}}) || (int'(len) > NUM_WORDS)) begin
            res = LEN_W'(NUM_WORDS);
        end else begin
            res = len;
        end
        return res;
    endfunction

    // Map beat count to physical beat slot: LE walks up from slot 0, BE walks
    // down from the top slot.
    function automatic logic [WIDTH-1:0] beat_sel(input logic [DW-1:0] d,
                                                  input logic [LEN_W-1:0] cnt);
        logic [WIDTH-1:0] res;
        res = {WIDTH{1'b0}};
        for (int k = 0; k < NUM_WORDS; k++) begin
            res = ((LITTLE_ENDIAN  && (int'(cnt) == k)) ||
                   (!LITTLE_ENDIAN && (int'(cnt) == NUM_WORDS - 1 - k)))
                  ? d[k*WIDTH +: WIDTH] : res;
        end
        return res;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_act_data;
    logic [DW-1:0]    r_pend_data;
    logic [DW-1:0]    w_act_data_nxt;
    logic [LEN_W-1:0] r_act_len;
    logic [LEN_W-1:0] r_pend_len;
    logic [LEN_W-1:0] w_act_len_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_data_out;
    logic             r_last_out;
    logic             w_ready;
    logic             w_valid;
    logic             w_in_xfer;
    logic             w_beat_xfer;
    logic             w_last_xfer;
    logic             w_load_act_in;
    logic             w_load_act_pend;
    logic             w_load_pend;

    // Handshake qualifiers, all derived from registered state.
    always_comb begin
        w_ready         = (r_state != ST_FULL);
        w_valid         = (r_state != ST_EMPTY);
        w_in_xfer       = io_bus.i_valid & w_ready;
        w_beat_xfer     = w_valid & io_bus.i_ready;
        w_last_xfer     = w_beat_xfer & r_last_out;
        // A new word goes straight to active when active is empty or just drained.
        w_load_act_in   = w_in_xfer & ((r_state == ST_EMPTY) ||
                                       ((r_state == ST_ACTIVE) & w_last_xfer));
        w_load_act_pend = (r_state == ST_FULL) & w_last_xfer;
        w_load_pend     = w_in_xfer & (r_state == ST_ACTIVE) & ~w_last_xfer;
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Occupancy next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) w_state_nxt = ST_ACTIVE;
                else           w_state_nxt = ST_EMPTY;
            end
            ST_ACTIVE: begin
                if (w_last_xfer && !w_in_xfer)      w_state_nxt = ST_EMPTY;
                else if (!w_last_xfer && w_in_xfer) w_state_nxt = ST_FULL;
                else                                w_state_nxt = ST_ACTIVE;
            end
            ST_FULL: begin
                if (w_last_xfer) w_state_nxt = ST_ACTIVE;
                else             w_state_nxt = ST_FULL;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Output decode from registered state and registered beat.
    always_comb begin
        io_bus.o_ready = w_ready;
        io_bus.o_valid = w_valid;
        io_bus.o_data  = r_data_out;
        io_bus.o_last  = r_last_out;
        o_busy         = w_valid;
    end

    // Next contents of the active register and its beat counter.
    always_comb begin
        w_act_data_nxt = r_act_data;
        w_act_len_nxt  = r_act_len;
        w_cnt_nxt      = r_cnt;
        if (w_load_act_in) begin
            w_act_data_nxt = io_bus.i_data;
            w_act_len_nxt  = clamp_len(io_bus.i_len);
            w_cnt_nxt      = {LEN_W{1'b0}};
        end else if (w_load_act_pend) begin
            w_act_data_nxt = r_pend_data;
            w_act_len_nxt  = r_pend_len;
            w_cnt_nxt      = {LEN_W{1'b0}};
        end else if (w_beat_xfer && !w_last_xfer) begin
            w_cnt_nxt      = r_cnt + LEN_W'(1);
        end else begin
            w_cnt_nxt      = r_cnt;
        end
    end

    // Datapath registers; the output beat is precomputed from next-cycle contents
    // so o_data/o_last are registered yet valid in the cycle after acceptance.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_act_data  <= {DW{1'b0}};
            r_act_len   <= {LEN_W{1'b0}};
            r_pend_data <= {DW{1'b0}};
            r_pend_len  <= {LEN_W{1'b0}};
            r_cnt       <= {LEN_W{1'b0}};
            r_data_out  <= {WIDTH{1'b0}};
            r_last_out  <= 1'b0;
        end else begin
            r_act_data <= w_act_data_nxt;
            r_act_len  <= w_act_len_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_load_pend) begin
                r_pend_data <= io_bus.i_data;
                r_pend_len  <= clamp_len(io_bus.i_len);
            end
            if (w_state_nxt == ST_EMPTY) begin
                r_data_out <= {WIDTH{1'b0}};
                r_last_out <= 1'b0;
            end else begin
                r_data_out <= beat_sel(w_act_data_nxt, w_cnt_nxt);
                r_last_out <= (w_cnt_nxt == (w_act_len_nxt - LEN_W'(1)));
            end
        end
    end
endmodule

// File: tb/tb_stream_serializer.sv
// ---------------------------------------------------------------------------
// tb_stream_serializer
// Drives a big-endian and a little-endian instance with identical stimulus and
// checks both against a word/beat queue reference model, a vector table and
// hand-written corner sequences (streaming, stalls, async reset).
// ---------------------------------------------------------------------------
module tb_stream_serializer;
    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        int         cyc;
    } cap_t;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  len;
        int          n;
        logic [31:0] exp_le0;   // first beat in the top byte
        logic [31:0] exp_le1;
    } vec_t;

    logic clk;
    logic rst_n;
    logic busy0;
    logic busy1;

    stream_serializer_if #(.WIDTH(8), .NUM_WORDS(4)) bus0 ();
    stream_serializer_if #(.WIDTH(8), .NUM_WORDS(4)) bus1 ();

    stream_serializer #(.WIDTH(8), .NUM_WORDS(4), .LITTLE_ENDIAN(1'b0)) dut0 (
        .clk(clk), .i_reset_n(rst_n), .io_bus(bus0), .o_busy(busy0)
    );
    stream_serializer #(.WIDTH(8), .NUM_WORDS(4), .LITTLE_ENDIAN(1'b1)) dut1 (
        .clk(clk), .i_reset_n(rst_n), .io_bus(bus1), .o_busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    int    words = 0;
    int    cyc   = 0;
    beat_t q0[$];
    beat_t q1[$];
    cap_t  cap0[$];
    cap_t  cap1[$];
    logic  prev_stall = 1'b0;
    logic [7:0] prev_d0;
    logic [7:0] prev_d1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] l, input logic r);
        bus0.i_valid = v; bus0.i_data = d; bus0.i_len = l; bus0.i_ready = r;
        bus1.i_valid = v; bus1.i_data = d; bus1.i_len = l; bus1.i_ready = r;
    endtask

    // Reference: an accepted word becomes its list of beats in emission order.
    task automatic push_word(input logic [31:0] d, input logic [2:0] l);
        int    n;
        beat_t b;
        n = ((l == 3'd0) || (l > 3'd4)) ? 4 : int'(l);
        for (int j = 0; j < n; j++) begin
            b.d = d[(3-j)*8 +: 8]; b.l = (j == n - 1); q0.push_back(b);
            b.d = d[j*8 +: 8];     b.l = (j == n - 1); q1.push_back(b);
        end
    endtask

    task automatic clear_model();
        q0.delete(); q1.delete(); words = 0; prev_stall = 1'b0;
    endtask

    // One clock cycle: called just after a falling edge, returns at the next one.
    task automatic step(input logic v, input logic [31:0] d, input logic [2:0] l, input logic r);
        logic  in_x;
        logic  bx;
        beat_t b;
        cap_t  c;
        drive(v, d, l, r);
        #1;
        chk("valid0", 32'(bus0.o_valid), 32'(words > 0));
        chk("valid1", 32'(bus1.o_valid), 32'(words > 0));
        chk("ready0", 32'(bus0.o_ready), 32'(words < 2));
        chk("ready1", 32'(bus1.o_ready), 32'(words < 2));
        chk("busy0",  32'(busy0),        32'(words > 0));
        chk("busy1",  32'(busy1),        32'(words > 0));
        if (words > 0) begin
            chk("data0", 32'(bus0.o_data), 32'(q0[0].d));
            chk("last0", 32'(bus0.o_last), 32'(q0[0].l));
            chk("data1", 32'(bus1.o_data), 32'(q1[0].d));
            chk("last1", 32'(bus1.o_last), 32'(q1[0].l));
        end else begin
            chk("idle_last0", 32'(bus0.o_last), 32'd0);
        end
        if (prev_stall) begin
            chk("stall_hold0", 32'(bus0.o_data), 32'(prev_d0));
            chk("stall_hold1", 32'(bus1.o_data), 32'(prev_d1));
        end
        in_x       = v && (words < 2);
        bx         = (words > 0) && r;
        prev_stall = (words > 0) && !r;
        prev_d0    = bus0.o_data;
        prev_d1    = bus1.o_data;
        if (bx) begin
            c.d = bus0.o_data; c.l = bus0.o_last; c.cyc = cyc; cap0.push_back(c);
            c.d = bus1.o_data; c.l = bus1.o_last; c.cyc = cyc; cap1.push_back(c);
            b = q0.pop_front();
            void'(q1.pop_front());
            if (b.l) words--;
        end
        if (in_x) begin
            push_word(d, l);
            words++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 3'd0, 1'b1);
    endtask

    vec_t        tv[6];
    int          refused;
    logic        acc;
    logic [63:0] ab;
    logic [31:0] e;
    logic [31:0] e1;
    int          pat[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{32'h12345678, 3'd4, 4, 32'h12345678, 32'h78563412};
        tv[1] = '{32'hAABBCCDD, 3'd2, 2, 32'hAABB0000, 32'hDDCC0000};
        tv[2] = '{32'hAABBCCDD, 3'd0, 4, 32'hAABBCCDD, 32'hDDCCBBAA};
        tv[3] = '{32'hAABBCCDD, 3'd7, 4, 32'hAABBCCDD, 32'hDDCCBBAA};
        tv[4] = '{32'hAABBCCDD, 3'd1, 1, 32'hAA000000, 32'hDD000000};
        tv[5] = '{32'h01020304, 3'd3, 3, 32'h01020300, 32'h04030200};
        pat   = '{1, 0, 0, 1, 0, 1, 1};

        // Reset values
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 3'd0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(bus0.o_valid), 32'd0);
        chk("rst_data",  32'(bus0.o_data),  32'd0);
        chk("rst_last",  32'(bus0.o_last),  32'd0);
        chk("rst_busy",  32'(busy0),        32'd0);
        chk("rst_ready", 32'(bus0.o_ready), 32'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Vector table: single words, full drain
        for (int i = 0; i < 6; i++) begin
            cap0.delete(); cap1.delete();
            step(1'b1, tv[i].data, tv[i].len, 1'b1);
            idle(7);
            chk("tv_cnt0", 32'(cap0.size()), 32'(tv[i].n));
            chk("tv_cnt1", 32'(cap1.size()), 32'(tv[i].n));
            e  = tv[i].exp_le0;
            e1 = tv[i].exp_le1;
            for (int j = 0; j < tv[i].n && j < cap0.size() && j < cap1.size(); j++) begin
                chk("tv_beat0", 32'(cap0[j].d), 32'(e[31-8*j -: 8]));
                chk("tv_beat1", 32'(cap1[j].d), 32'(e1[31-8*j -: 8]));
                chk("tv_lastf", 32'(cap0[j].l), 32'(j == tv[i].n - 1));
            end
        end

        // Back-to-back words, third word held off while full
        cap0.delete(); cap1.delete();
        step(1'b1, 32'h12345678, 3'd4, 1'b1);
        step(1'b1, 32'h9ABCDEF0, 3'd4, 1'b1);
        chk("full_ready0", 32'(bus0.o_ready), 32'd0);
        refused = 0;
        for (int k = 0; k < 10; k++) begin
            acc = (words < 2);
            step(1'b1, 32'h0F1E2D3C, 3'd4, 1'b1);
            if (acc) break;
            refused++;
        end
        chk("held_cycles", 32'(refused), 32'd3);
        idle(10);
        chk("stream_cnt", 32'(cap0.size()), 32'd12);
        ab = 64'h123456789ABCDEF0;
        if (cap0.size() >= 8) begin
            chk("stream_gap", 32'(cap0[7].cyc - cap0[0].cyc), 32'd7);
            for (int j = 0; j < 8; j++) chk("stream_beat", 32'(cap0[j].d), 32'(ab[63-8*j -: 8]));
        end

        // Stall pattern on a single word
        cap0.delete(); cap1.delete();
        step(1'b1, 32'h12345678, 3'd4, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b0, 32'h0, 3'd0, pat[k] != 0);
        chk("stall_cnt", 32'(cap0.size()), 32'd4);
        if (cap0.size() == 4) begin
            chk("stall_b0", 32'(cap0[0].d), 32'h12);
            chk("stall_b3", 32'(cap0[3].d), 32'h78);
            chk("stall_l3", 32'(cap0[3].l), 32'd1);
        end
        idle(2);
        chk("stall_cnt_after", 32'(cap0.size()), 32'd4);

        // Async reset mid-word with a pending word
        step(1'b1, 32'h12345678, 3'd4, 1'b1);
        step(1'b1, 32'hCAFEF00D, 3'd4, 1'b1);
        step(1'b0, 32'h0, 3'd0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(bus0.o_valid), 32'd0);
        chk("mrst_data",  32'(bus0.o_data),  32'd0);
        chk("mrst_last",  32'(bus0.o_last),  32'd0);
        chk("mrst_busy",  32'(busy1),        32'd0);
        chk("mrst_ready", 32'(bus1.o_ready), 32'd1);
        clear_model();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        cap0.delete(); cap1.delete();
        idle(6);
        chk("mrst_residual", 32'(cap0.size() + cap1.size()), 32'd0);

        // Randomized traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 99) < 60, $urandom, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 70);
        end
        idle(20);
        chk("drain_busy0", 32'(busy0), 32'd0);
        chk("drain_busy1", 32'(busy1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
